// File: rtl/dmem_wbuf_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_wbuf_responder_if
//  Description : MEM-stage data-port bundle between the pipeline (master)
//                and the write-buffered data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_wbuf_responder_if;
  logic        Memread;
  logic        Memwrite;
  logic [31:0] Ex_Mem_out3;
  logic [31:0] Ex_Mem_out4;
  logic [31:0] Memory_out;
  logic        mem_stall;

  modport master (
    output Memread, Memwrite, Ex_Mem_out3, Ex_Mem_out4,
    input  Memory_out, mem_stall
  );

  modport slave (
    input  Memread, Memwrite, Ex_Mem_out3, Ex_Mem_out4,
    output Memory_out, mem_stall
  );
endinterface
`default_nettype wire

// File: rtl/dmem_wbuf_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_wbuf_responder
//  Description : Data memory with a posted-store FIFO write buffer,
//                youngest-match store-to-load forwarding, stall output and
//                a flush handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_wbuf_responder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  wire                        clk,
  input  wire                        rst,        // async, active-low
  dmem_wbuf_responder_if.slave       bus,
  input  wire                        dbg_hold,
  input  wire                        flush_req,
  output logic                       flush_done,
  output logic [$clog2(DEPTH):0]     wb_count
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_pw-1:0]     wr_ptr_q, wr_ptr_d;
  logic [c_pw-1:0]     rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]     count_q, count_d;
  logic                flush_done_q, flush_done_d;

  logic [ADDR_W-1:0]   buf_idx_q  [DEPTH];
  logic [31:0]         buf_data_q [DEPTH];
  logic [31:0]         mem_q      [2**ADDR_W];

  logic [ADDR_W-1:0]   w_idx;
  logic                w_serve;
  logic                w_drain_en;
  logic                w_push;
  logic                w_fwd_hit;
  logic [31:0]         w_fwd_data;
  logic [c_pw-1:0]     w_pos;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.Ex_Mem_out3[31:ADDR_W+2], bus.Ex_Mem_out3[1:0]};

  assign w_idx = bus.Ex_Mem_out3[ADDR_W+1:2];

  // Port arbitration, store acceptance, forwarding and next-state logic
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    flush_done_d = 1'b0;
    w_fwd_hit    = 1'b0;
    w_fwd_data   = 32'h0;
    w_pos        = '0;

    // FLUSH owns the array port; IDLE and DONE serve requests normally
    w_serve = (state_q != ST_FLUSH);

    // A load in a serving state wins the single array port over draining
    w_drain_en = !dbg_hold && (count_q != '0) && (!w_serve || !bus.Memread);
    w_push     = w_serve && bus.Memwrite && ((count_q < c_full) || w_drain_en);

    // Scan oldest to youngest so the last match is the youngest store
    for (int k = 0; k < DEPTH; k++) begin
      w_pos = rd_ptr_q + c_pw'(k);
      if ((c_cw'(k) < count_q) && (buf_idx_q[w_pos] == w_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = buf_data_q[w_pos];
      end
    end

    if (w_serve && bus.Memread)
      bus.Memory_out = w_fwd_hit ? w_fwd_data : mem_q[w_idx];
    else
      bus.Memory_out = 32'h0;

    if (w_serve)
      bus.mem_stall = bus.Memwrite && !w_push;
    else
      bus.mem_stall = bus.Memread || bus.Memwrite;

    if (w_push)     wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_drain_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_drain_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Leave FLUSH on the edge that empties the buffer (or at once if empty)
    case (state_q)
      ST_IDLE:  if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (count_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    flush_done_d = (state_d == ST_DONE);
  end

  // Control state: pointers, occupancy, FSM and flush pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Buffer payload and word array hold data only; they are never reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      buf_idx_q[wr_ptr_q]  <= w_idx;
      buf_data_q[wr_ptr_q] <= bus.Ex_Mem_out4;
    end
    if (w_drain_en)
      mem_q[buf_idx_q[rd_ptr_q]] <= buf_data_q[rd_ptr_q];
  end

  assign wb_count   = count_q;
  assign flush_done = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wbuf_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_wbuf_responder
//  Description : Directed self-checking bench for dmem_wbuf_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_wbuf_responder;

  logic       clk;
  logic       rst;
  logic       dbg_hold;
  logic       flush_req;
  logic       flush_done;
  logic [2:0] wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_wbuf_responder_if bus ();

  dmem_wbuf_responder #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .dbg_hold   (dbg_hold),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.Memread     = rd;
    bus.Memwrite    = wr;
    bus.Ex_Mem_out3 = a;
    bus.Ex_Mem_out4 = d;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'h0);
    check(tag, bus.Memory_out, exp);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; dbg_hold = 1'b0; flush_req = 1'b0;
    bus.Memread = 1'b0; bus.Memwrite = 1'b0;
    bus.Ex_Mem_out3 = 32'h0; bus.Ex_Mem_out4 = 32'h0;
    #3;
    check("rst_count", 32'(wb_count), 32'd0);
    check("rst_fdone", 32'(flush_done), 32'd0);
    check("rst_mout", bus.Memory_out, 32'h0);
    check("rst_stall", 32'(bus.mem_stall), 32'd0);
    #9 rst = 1'b1;
    tick();

    // Forwarding from a single buffered store while loads block the drain
    store(32'h40, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h40, 32'h0);
      check("fwd1_data", bus.Memory_out, 32'hDEADBEEF);
      check("fwd1_stall", 32'(bus.mem_stall), 32'd0);
      check("fwd1_count", 32'(wb_count), 32'd1);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("drain1_count", 32'(wb_count), 32'd0);
    load_chk("arr_40", 32'h40, 32'hDEADBEEF);

    // Duplicate indices: youngest wins, drain order preserved
    dbg_hold = 1'b1;
    store(32'h10, 32'h1);
    store(32'h14, 32'h2);
    store(32'h10, 32'h3);
    check("dup_count", 32'(wb_count), 32'd3);
    load_chk("dup_fwd10", 32'h10, 32'h3);
    load_chk("dup_fwd14", 32'h14, 32'h2);
    dbg_hold = 1'b0;
    tick(); tick(); tick();
    check("dup_drained", 32'(wb_count), 32'd0);
    load_chk("arr_4", 32'h10, 32'h3);
    load_chk("arr_5", 32'h14, 32'h2);

    // Full buffer stalls, then push+pop together when the hold drops
    dbg_hold = 1'b1;
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4*i), 32'hA0 + 32'(i));
    check("full_count", 32'(wb_count), 32'd4);
    drive(1'b0, 1'b1, 32'h110, 32'hA4);
    check("full_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    check("full_hold_cnt", 32'(wb_count), 32'd4);
    dbg_hold = 1'b0;
    #1;
    check("pushpop_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    check("pushpop_cnt", 32'(wb_count), 32'd4);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("full_drained", 32'(wb_count), 32'd0);
    load_chk("arr_110", 32'h110, 32'hA4);
    load_chk("arr_100", 32'h100, 32'hA0);

    // Load+store on a full buffer: old value returned, store stalled
    store(32'h80, 32'h12345678);
    tick();
    dbg_hold = 1'b1;
    for (int i = 0; i < 4; i++) store(32'h200 + 32'(4*i), 32'hB0 + 32'(i));
    dbg_hold = 1'b0;
    drive(1'b1, 1'b1, 32'h80, 32'h55);
    check("rw_data", bus.Memory_out, 32'h12345678);
    check("rw_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    check("rw_count", 32'(wb_count), 32'd4);
    drive(1'b0, 1'b1, 32'h80, 32'h55);
    check("w_only_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    check("w_only_cnt", 32'(wb_count), 32'd4);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    load_chk("arr_80", 32'h80, 32'h55);

    // Flush of three entries with a load held high throughout
    dbg_hold = 1'b1;
    for (int i = 0; i < 3; i++) store(32'h300 + 32'(4*i), 32'hC0 + 32'(i));
    dbg_hold = 1'b0;
    flush_req = 1'b1;
    drive(1'b1, 1'b0, 32'h300, 32'h0);
    check("fl_req_stall", 32'(bus.mem_stall), 32'd0);
    check("fl_req_data", bus.Memory_out, 32'hC0);
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fl_stall", 32'(bus.mem_stall), 32'd1);
      check("fl_mout", bus.Memory_out, 32'h0);
      check("fl_fdone", 32'(flush_done), 32'd0);
      tick();
    end
    check("done_fdone", 32'(flush_done), 32'd1);
    check("done_stall", 32'(bus.mem_stall), 32'd0);
    check("done_count", 32'(wb_count), 32'd0);
    check("done_data", bus.Memory_out, 32'hC0);
    tick();
    check("post_fdone", 32'(flush_done), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    load_chk("arr_308", 32'h308, 32'hC2);

    // Async reset during FLUSH discards buffered stores
    store(32'h400, 32'h11);
    store(32'h404, 32'h22);
    tick();
    dbg_hold = 1'b1;
    store(32'h400, 32'hD0);
    store(32'h404, 32'hD1);
    flush_req = 1'b1;
    tick();
    tick();
    check("rstf_count", 32'(wb_count), 32'd2);
    drive(1'b1, 1'b0, 32'h400, 32'h0);
    check("rstf_stall_pre", 32'(bus.mem_stall), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rstf_count0", 32'(wb_count), 32'd0);
    check("rstf_idle", 32'(bus.mem_stall), 32'd0);
    check("rstf_old400", bus.Memory_out, 32'h11);
    check("rstf_fdone", 32'(flush_done), 32'd0);
    flush_req = 1'b0;
    dbg_hold  = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstf_nopulse", 32'(flush_done), 32'd0);
    end
    load_chk("rstf_old404", 32'h404, 32'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
